// File: rtl/jtpopeye_obj_pkg.sv
// Shared definitions for the Popeye object scan path.
//   state_t      : object scan sequencer states
//   obj_word_t   : 29-bit object word layout as presented on DO
//                  X[7:0], Y[15:8], id[22:16], hflip 23, pal[26:24], vflip 27, bank 28
//   OBJ_Y_EMPTY  : Y value marking an unused table entry (also used by the DMA writer)
package jtpopeye_obj_pkg;

    localparam int unsigned OBJ_DW = 29;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_PRESENT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       bank;   // 28
        logic       vflip;  // 27
        logic [2:0] pal;    // 26:24
        logic       hflip;  // 23
        logic [6:0] id;     // 22:16
        logic [7:0] y;      // 15:8
        logic [7:0] x;      // 7:0
    } obj_word_t;

    localparam logic [7:0] OBJ_Y_EMPTY = 8'h00;

    function automatic logic obj_is_empty(input obj_word_t w);
        return w.y == OBJ_Y_EMPTY;
    endfunction

endpackage

// File: rtl/jtpopeye_obj_scan_if.sv
// Object scan bus: attribute RAM port plus the object word stream to jtpopeye_buf.
//   obj_addr  scanner -> RAM     {bank, entry}
//   obj_data  RAM -> scanner     synchronous read data, valid 1 clk after obj_addr
//   DO        scanner -> buffer  object word
//   ROHVS     scanner -> buffer  1 = slot invalid, no write
//   ROHVCK    scanner -> buffer  field flag
//   busy      scanner -> any     line scan in progress
// modport master: the scanner; modport slave: RAM/buffer side.
interface jtpopeye_obj_scan_if
    import jtpopeye_obj_pkg::*;
#(
    parameter int unsigned OBJ_AW = 6
);
    logic [OBJ_AW:0]   obj_addr;
    logic [OBJ_DW-1:0] obj_data;
    logic [OBJ_DW-1:0] DO;
    logic              ROHVS;
    logic              ROHVCK;
    logic              busy;

    modport master (
        output obj_addr, DO, ROHVS, ROHVCK, busy,
        input  obj_data
    );

    modport slave (
        input  obj_addr, DO, ROHVS, ROHVCK, busy,
        output obj_data
    );
endinterface

// File: rtl/jtpopeye_obj_scan.sv
// Per-line object table sequencer feeding jtpopeye_buf.
// At line start (H0_cen, HB=1, H=FF) it walks SLOTS entries of the selected
// attribute table bank and presents one object word per 2-pixel slot. DO/ROHVS
// update on odd-H H0_cen pulses and hold through the following even H.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   H0_cen          one pulse per H count (>= 4 clk apart)
//   H, V            horizontal / vertical counters
//   HB              horizontal blank
//   obj_bank        table bank, sampled at line start
//   bus (master)    obj_addr/obj_data RAM port, DO/ROHVS/ROHVCK/busy outputs
// OBJ_AW must match the interface instance; SLOTS <= 2**OBJ_AW and SLOTS <= 128.
module jtpopeye_obj_scan
    import jtpopeye_obj_pkg::*;
#(
    parameter int unsigned OBJ_AW = 6,
    parameter int unsigned SLOTS  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       H0_cen,
    input  logic [7:0]                 H,
    input  logic [7:0]                 V,
    input  logic                       HB,
    input  logic                       obj_bank,
    jtpopeye_obj_scan_if.master        bus
);

    localparam logic [6:0] SLOT_LAST = 7'(SLOTS - 1);

    state_t            r_state;
    logic [6:0]        r_slot;
    logic              r_bank_l;
    logic              r_busy;
    logic [OBJ_AW:0]   r_addr;
    obj_word_t         r_nxt;
    logic              r_nxt_vld;
    logic              r_hb_l;
    logic [7:0]        r_v_l;
    logic              r_rohvck;
    logic [OBJ_DW-1:0] r_do;
    logic              r_rohvs;

    logic              w_line_start;
    logic              w_abort;
    logic              w_odd_cen;
    logic              w_present;
    logic              w_finish;
    logic [6:0]        w_slot_nxt;

    // Line start wins over an HB-rise abort on the same pulse: it restarts the scan.
    assign w_line_start = H0_cen & HB & (H == 8'hFF);
    assign w_abort      = H0_cen & HB & ~r_hb_l & r_busy & ~w_line_start;
    assign w_odd_cen    = H0_cen & H[0];
    assign w_present    = w_odd_cen & (r_state == ST_PRESENT) & ~w_line_start & ~w_abort;
    assign w_finish     = w_odd_cen & (r_state == ST_DONE)    & ~w_line_start & ~w_abort;
    assign w_slot_nxt   = r_slot + 7'd1;

    // Sequencer. obj_addr is loaded on entry to FETCH so the synchronous RAM
    // returns data in time for LATCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_slot    <= '0;
            r_bank_l  <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_nxt     <= '0;
            r_nxt_vld <= 1'b0;
            r_hb_l    <= 1'b0;
        end else begin
            if (H0_cen) r_hb_l <= HB;
            if (w_line_start) begin
                r_bank_l <= obj_bank;
                r_slot   <= '0;
                r_busy   <= 1'b1;
                r_addr   <= {obj_bank, {OBJ_AW{1'b0}}};
                r_state  <= ST_FETCH;
            end else if (w_abort) begin
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_FETCH: r_state <= ST_LATCH;
                    ST_LATCH: begin
                        r_nxt     <= obj_word_t'(bus.obj_data);
                        r_nxt_vld <= ~obj_is_empty(obj_word_t'(bus.obj_data));
                        r_state   <= ST_PRESENT;
                    end
                    ST_PRESENT: begin
                        if (w_present) begin
                            if (r_slot == SLOT_LAST) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_slot  <= w_slot_nxt;
                                r_addr  <= {r_bank_l, OBJ_AW'(w_slot_nxt)};
                                r_state <= ST_FETCH;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (w_finish) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Field flag: toggles when V wraps FF -> 00, independent of the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v_l    <= '0;
            r_rohvck <= 1'b0;
        end else if (H0_cen) begin
            r_v_l <= V;
            if (V == 8'h00 && r_v_l == 8'hFF) r_rohvck <= ~r_rohvck;
        end
    end

    // Output word register. DO is held when a slot is invalidated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_do    <= '0;
            r_rohvs <= 1'b1;
        end else if (w_line_start | w_abort | w_finish) begin
            r_rohvs <= 1'b1;
        end else if (w_present) begin
            r_do    <= r_nxt;
            r_rohvs <= ~r_nxt_vld;
        end
    end

    assign bus.obj_addr = r_addr;
    assign bus.DO       = r_do;
    assign bus.ROHVS    = r_rohvs;
    assign bus.ROHVCK   = r_rohvck;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_jtpopeye_obj_scan.sv
// Directed bench for jtpopeye_obj_scan with a synchronous attribute RAM model.
module tb_jtpopeye_obj_scan;

    localparam int unsigned AW = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       H0_cen = 1'b0;
    logic [7:0] H = 8'h00;
    logic [7:0] V = 8'h40;
    logic       HB = 1'b0;
    logic       obj_bank = 1'b0;

    logic [28:0] mem [0:127];

    int n_cmp = 0;
    int n_bad = 0;

    jtpopeye_obj_scan_if #(.OBJ_AW(AW)) bus ();

    jtpopeye_obj_scan #(.OBJ_AW(AW), .SLOTS(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .H0_cen   (H0_cen),
        .H        (H),
        .V        (V),
        .HB       (HB),
        .obj_bank (obj_bank),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.obj_data <= mem[bus.obj_addr];

    // Table word: bank/vflip/pal/hflip/id/Y/X
    function automatic logic [28:0] mk(input logic b, input int k, input logic [7:0] y);
        logic [6:0] kk;
        logic [7:0] x;
        kk = 7'(k);
        x  = b ? (8'h40 + 8'(k)) : (8'h80 + 8'(k));
        return {b, kk[1], kk[2:0], kk[0], kk, y, x};
    endfunction

    task automatic fill_table();
        for (int k = 0; k < 64; k++) begin
            mem[k]      = mk(1'b0, k, 8'h10 + 8'(k));
            mem[64 + k] = mk(1'b1, k, 8'h20 + 8'(k));
        end
    endtask

    task automatic tick(input logic [7:0] h, input logic hb);
        @(negedge clk);
        H = h; HB = hb; H0_cen = 1'b1;
        @(negedge clk);
        H0_cen = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tick(8'hFF, 1'b1);
        n_cmp++; if (bus.ROHVS !== 1'b1) begin n_bad++; $display("FAIL rst_rohvs: got %b want 1", bus.ROHVS); end
        n_cmp++; if (bus.DO !== 29'h0) begin n_bad++; $display("FAIL rst_do: got %h want 0", bus.DO); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.ROHVCK !== 1'b0) begin n_bad++; $display("FAIL rst_rohvck: got %b want 0", bus.ROHVCK); end
        n_cmp++; if (bus.obj_addr !== 7'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", bus.obj_addr); end
        @(negedge clk); rst_n = 1'b1;
        tick(8'h80, 1'b1);
        tick(8'hFE, 1'b1);
        tick(8'hFF, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h01, 1'b0);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.ROHVS !== 1'b1) begin n_bad++; $display("FAIL idle_rohvs: got %b want 1", bus.ROHVS); end
    endtask

    task automatic test_full_line();
        tick(8'hFF, 1'b1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t2_busy_start: got %b want 1", bus.busy); end
        for (int k = 0; k < 64; k++) begin
            tick(8'(2 * k), 1'b0);
            tick(8'(2 * k + 1), 1'b0);
            n_cmp++; if (bus.DO[15:8] !== 8'h10 + 8'(k)) begin n_bad++; $display("FAIL t2_y slot %0d: got %h want %h", k, bus.DO[15:8], 8'h10 + 8'(k)); end
            n_cmp++; if (bus.DO !== mk(1'b0, k, 8'h10 + 8'(k))) begin n_bad++; $display("FAIL t2_do slot %0d: got %h want %h", k, bus.DO, mk(1'b0, k, 8'h10 + 8'(k))); end
            n_cmp++; if (bus.ROHVS !== 1'b0) begin n_bad++; $display("FAIL t2_rohvs slot %0d: got %b want 0", k, bus.ROHVS); end
        end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t2_busy_last: got %b want 1", bus.busy); end
        tick(8'd128, 1'b0);
        tick(8'd129, 1'b0);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t2_busy_end: got %b want 0", bus.busy); end
        n_cmp++; if (bus.ROHVS !== 1'b1) begin n_bad++; $display("FAIL t2_rohvs_end: got %b want 1", bus.ROHVS); end
        n_cmp++; if (bus.DO !== mk(1'b0, 63, 8'h4F)) begin n_bad++; $display("FAIL t2_do_hold: got %h want %h", bus.DO, mk(1'b0, 63, 8'h4F)); end
        tick(8'd130, 1'b0);
        tick(8'd131, 1'b0);
        n_cmp++; if (bus.DO !== mk(1'b0, 63, 8'h4F)) begin n_bad++; $display("FAIL t2_no_wrap: got %h want %h", bus.DO, mk(1'b0, 63, 8'h4F)); end
    endtask

    task automatic test_empty_entries();
        logic exp_vs;
        mem[5] = mk(1'b0, 5, 8'h00);
        mem[9] = mk(1'b0, 9, 8'h00);
        tick(8'hFF, 1'b1);
        for (int k = 0; k < 12; k++) begin
            tick(8'(2 * k), 1'b0);
            tick(8'(2 * k + 1), 1'b0);
            exp_vs = (k == 5 || k == 9);
            n_cmp++; if (bus.ROHVS !== exp_vs) begin n_bad++; $display("FAIL t3_rohvs slot %0d: got %b want %b", k, bus.ROHVS, exp_vs); end
            n_cmp++; if (bus.DO[7:0] !== 8'h80 + 8'(k)) begin n_bad++; $display("FAIL t3_x slot %0d: got %h want %h", k, bus.DO[7:0], 8'h80 + 8'(k)); end
        end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t3_busy: got %b want 1", bus.busy); end
        tick(8'd24, 1'b1);
        mem[5] = mk(1'b0, 5, 8'h15);
        mem[9] = mk(1'b0, 9, 8'h19);
    endtask

    task automatic test_bank();
        obj_bank = 1'b1;
        tick(8'hFF, 1'b1);
        for (int k = 0; k < 64; k++) begin
            if (k == 10) obj_bank = 1'b0;
            tick(8'(2 * k), 1'b0);
            tick(8'(2 * k + 1), 1'b0);
            n_cmp++; if (bus.obj_addr[AW] !== 1'b1) begin n_bad++; $display("FAIL t4_addr_bank slot %0d: got %b want 1", k, bus.obj_addr[AW]); end
            n_cmp++; if (bus.DO !== mk(1'b1, k, 8'h20 + 8'(k))) begin n_bad++; $display("FAIL t4_do slot %0d: got %h want %h", k, bus.DO, mk(1'b1, k, 8'h20 + 8'(k))); end
        end
        tick(8'd128, 1'b0);
        tick(8'd129, 1'b0);
        tick(8'hFF, 1'b1);
        n_cmp++; if (bus.obj_addr !== 7'h00) begin n_bad++; $display("FAIL t4_next_addr: got %h want 00", bus.obj_addr); end
        tick(8'h00, 1'b0);
        tick(8'h01, 1'b0);
        n_cmp++; if (bus.DO !== mk(1'b0, 0, 8'h10)) begin n_bad++; $display("FAIL t4_next_do: got %h want %h", bus.DO, mk(1'b0, 0, 8'h10)); end
        n_cmp++; if (bus.obj_addr !== 7'h01) begin n_bad++; $display("FAIL t4_next_addr1: got %h want 01", bus.obj_addr); end
        tick(8'h02, 1'b1);
    endtask

    task automatic test_hb_abort();
        tick(8'h10, 1'b0);
        tick(8'hFF, 1'b1);
        for (int k = 0; k <= 20; k++) begin
            tick(8'(2 * k), 1'b0);
            tick(8'(2 * k + 1), 1'b0);
        end
        n_cmp++; if (bus.DO !== mk(1'b0, 20, 8'h24)) begin n_bad++; $display("FAIL t5_slot20: got %h want %h", bus.DO, mk(1'b0, 20, 8'h24)); end
        tick(8'd42, 1'b1);
        n_cmp++; if (bus.ROHVS !== 1'b1) begin n_bad++; $display("FAIL t5_abort_rohvs: got %b want 1", bus.ROHVS); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t5_abort_busy: got %b want 0", bus.busy); end
        tick(8'd43, 1'b1);
        tick(8'd44, 1'b0);
        tick(8'd45, 1'b0);
        n_cmp++; if (bus.ROHVS !== 1'b1) begin n_bad++; $display("FAIL t5_stay_idle: got %b want 1", bus.ROHVS); end
        n_cmp++; if (bus.DO !== mk(1'b0, 20, 8'h24)) begin n_bad++; $display("FAIL t5_do_hold: got %h want %h", bus.DO, mk(1'b0, 20, 8'h24)); end
        tick(8'hFF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(8'(2 * k), 1'b0);
            tick(8'(2 * k + 1), 1'b0);
        end
        n_cmp++; if (bus.DO !== mk(1'b0, 3, 8'h13)) begin n_bad++; $display("FAIL t5_slot3: got %h want %h", bus.DO, mk(1'b0, 3, 8'h13)); end
        tick(8'hFF, 1'b1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t5_restart_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.ROHVS !== 1'b1) begin n_bad++; $display("FAIL t5_restart_rohvs: got %b want 1", bus.ROHVS); end
        tick(8'h00, 1'b0);
        tick(8'h01, 1'b0);
        n_cmp++; if (bus.DO !== mk(1'b0, 0, 8'h10)) begin n_bad++; $display("FAIL t5_restart_do: got %h want %h", bus.DO, mk(1'b0, 0, 8'h10)); end
        n_cmp++; if (bus.ROHVS !== 1'b0) begin n_bad++; $display("FAIL t5_restart_vs: got %b want 0", bus.ROHVS); end
        tick(8'h02, 1'b1);
    endtask

    task automatic test_field_and_reset();
        V = 8'hFE; tick(8'h90, 1'b1);
        n_cmp++; if (bus.ROHVCK !== 1'b0) begin n_bad++; $display("FAIL t6_vck_fe: got %b want 0", bus.ROHVCK); end
        V = 8'hFF; tick(8'h91, 1'b1);
        n_cmp++; if (bus.ROHVCK !== 1'b0) begin n_bad++; $display("FAIL t6_vck_ff: got %b want 0", bus.ROHVCK); end
        V = 8'h00; tick(8'h92, 1'b1);
        n_cmp++; if (bus.ROHVCK !== 1'b1) begin n_bad++; $display("FAIL t6_vck_00: got %b want 1", bus.ROHVCK); end
        V = 8'h01; tick(8'h93, 1'b1);
        n_cmp++; if (bus.ROHVCK !== 1'b1) begin n_bad++; $display("FAIL t6_vck_01: got %b want 1", bus.ROHVCK); end
        tick(8'h94, 1'b1);
        n_cmp++; if (bus.ROHVCK !== 1'b1) begin n_bad++; $display("FAIL t6_vck_hold: got %b want 1", bus.ROHVCK); end
        tick(8'h95, 1'b0);
        tick(8'hFF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(8'(2 * k), 1'b0);
            tick(8'(2 * k + 1), 1'b0);
        end
        n_cmp++; if (bus.ROHVS !== 1'b0) begin n_bad++; $display("FAIL t6_prescan_vs: got %b want 0", bus.ROHVS); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.ROHVS !== 1'b1) begin n_bad++; $display("FAIL t6_arst_rohvs: got %b want 1", bus.ROHVS); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t6_arst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.DO !== 29'h0) begin n_bad++; $display("FAIL t6_arst_do: got %h want 0", bus.DO); end
        n_cmp++; if (bus.ROHVCK !== 1'b0) begin n_bad++; $display("FAIL t6_arst_vck: got %b want 0", bus.ROHVCK); end
        n_cmp++; if (bus.obj_addr !== 7'h0) begin n_bad++; $display("FAIL t6_arst_addr: got %h want 0", bus.obj_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(8'h08, 1'b0);
        tick(8'h09, 1'b0);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t6_post_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.DO !== 29'h0) begin n_bad++; $display("FAIL t6_post_do: got %h want 0", bus.DO); end
        tick(8'hFF, 1'b1);
        tick(8'h00, 1'b0);
        tick(8'h01, 1'b0);
        n_cmp++; if (bus.DO !== mk(1'b0, 0, 8'h10)) begin n_bad++; $display("FAIL t6_rescan_do: got %h want %h", bus.DO, mk(1'b0, 0, 8'h10)); end
        n_cmp++; if (bus.ROHVS !== 1'b0) begin n_bad++; $display("FAIL t6_rescan_vs: got %b want 0", bus.ROHVS); end
    endtask

    initial begin
        fill_table();
        test_reset();
        test_full_line();
        test_empty_entries();
        test_bank();
        test_hb_abort();
        test_field_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
